// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C engine: runs one START/STOP/WRITE/READ primitive per command,
// four divider quarter-ticks per bit, with clock stretching and arbitration detection.
module i2c_bit_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       div_clk_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_i,
  input  logic       cmd_bit_i,
  output logic       rsp_valid_o,
  output logic       rsp_bit_o,
  output logic       arb_lost_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_t_o,
  output logic       sda_t_o
);

  typedef enum logic [2:0] {ST_IDLE, ST_Q0, ST_Q1, ST_Q2, ST_Q3} state_t;
  typedef enum logic [1:0] {CMD_START = 2'b00, CMD_STOP = 2'b01,
                            CMD_WRITE = 2'b10, CMD_READ = 2'b11} cmd_t;

  state_t                 state;
  cmd_t                   cmd_q;
  logic                   bit_q;
  logic                   div_q;
  logic                   tick;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   lost;

  // Every divider edge, rising or falling, is one quarter of the bit period.
  assign tick  = div_clk_i ^ div_q;
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign lost  = !sda_s && (cmd_q == CMD_STOP || (cmd_q == CMD_WRITE && bit_q));

  // NOTE: synchronisers reset to 1 (idle bus level) so no phantom low is seen after reset.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      div_q    <= 1'b0;
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      div_q    <= div_clk_i;
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= ST_IDLE;
      cmd_q       <= CMD_START;
      bit_q       <= 1'b0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_bit_o   <= 1'b0;
      arb_lost_o  <= 1'b0;
      scl_t_o     <= 1'b1;
      sda_t_o     <= 1'b1;
    end else begin
      rsp_valid_o <= 1'b0;
      arb_lost_o  <= 1'b0;

      // Line drive is decoded from the current quarter, so it trails the state by one cycle.
      unique case (state)
        ST_IDLE: begin
          if (rsp_valid_o && arb_lost_o) begin
            scl_t_o <= 1'b1;
            sda_t_o <= 1'b1;
          end
        end
        ST_Q0: begin
          scl_t_o <= 1'b0;
          case (cmd_q)
            CMD_STOP:  sda_t_o <= 1'b0;
            CMD_WRITE: sda_t_o <= bit_q;
            default:   sda_t_o <= 1'b1;
          endcase
        end
        ST_Q1: begin
          scl_t_o <= 1'b1;
          if (cmd_q == CMD_START || cmd_q == CMD_READ) sda_t_o <= 1'b1;
          else if (cmd_q == CMD_STOP)                  sda_t_o <= 1'b0;
        end
        ST_Q2: begin
          scl_t_o <= 1'b1;
          if (cmd_q == CMD_START)                          sda_t_o <= 1'b0;
          else if (cmd_q == CMD_STOP || cmd_q == CMD_READ) sda_t_o <= 1'b1;
        end
        ST_Q3: begin
          scl_t_o <= (cmd_q == CMD_STOP);
          if (cmd_q == CMD_START)                          sda_t_o <= 1'b0;
          else if (cmd_q == CMD_STOP || cmd_q == CMD_READ) sda_t_o <= 1'b1;
        end
        default: ;
      endcase

      unique case (state)
        ST_IDLE: begin
          // A tick coinciding with acceptance is deliberately not consumed by Q0.
          if (cmd_valid_i) begin
            cmd_q       <= cmd_t'(cmd_i);
            bit_q       <= cmd_bit_i;
            cmd_ready_o <= 1'b0;
            state       <= ST_Q0;
          end
        end
        ST_Q0: if (tick) state <= ST_Q1;
        ST_Q1: if (tick && scl_s) state <= ST_Q2;
        ST_Q2: begin
          if (tick) begin
            rsp_bit_o <= sda_s;
            if (lost) begin
              state       <= ST_IDLE;
              cmd_ready_o <= 1'b1;
              rsp_valid_o <= 1'b1;
              arb_lost_o  <= 1'b1;
            end else begin
              state <= ST_Q3;
            end
          end
        end
        ST_Q3: begin
          if (tick) begin
            state       <= ST_IDLE;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_bit_ctrl.md
Name: i2c_bit_ctrl

Overview:
- Bit-level I2C engine directly downstream of the clock divider. Each edge of the divider output marks one quarter of an SCL bit period.
- Executes one bus primitive per command (START, STOP, WRITE bit, READ bit). Drives open-drain SCL/SDA through tri-state enables.
- Honours clock stretching and reports per-bit result and arbitration loss to the byte-level controller above it.
- Single clock domain clk_i; divider output is treated as a synchronous data signal, never as a clock.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for scl_i/sda_i (legal range 2..4).

Ports:
- clk_i  input  1  system clock
- arstn_i  input  1  asynchronous active-low reset
- div_clk_i  input  1  divider output, registered in clk_i domain; each edge = one quarter tick
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  engine idle, command accepted when valid&ready
- cmd_i  input  2  00 START, 01 STOP, 10 WRITE, 11 READ
- cmd_bit_i  input  1  bit to transmit for WRITE (ignored otherwise)
- rsp_valid_o  output  1  one-cycle pulse, command complete
- rsp_bit_o  output  1  SDA sampled in Q2 (all commands)
- arb_lost_o  output  1  qualified by rsp_valid_o, arbitration lost
- scl_i  input  1  SCL pad input (async)
- sda_i  input  1  SDA pad input (async)
- scl_t_o  output  1  1 = release SCL, 0 = pull low
- sda_t_o  output  1  1 = release SDA, 0 = pull low

Behaviour:
- Reset (arstn_i low, asynchronous): state IDLE, scl_t_o=1, sda_t_o=1, cmd_ready_o=1, rsp_valid_o=0, rsp_bit_o=0, arb_lost_o=0, synchronisers cleared to 1. Reset mid-command releases both lines immediately, with no STOP generated.
- Tick: div_q registered copy of div_clk_i; tick = div_clk_i ^ div_q (1-cycle pulse per edge). The tick must not depend on the divider phase at command acceptance.
- scl_s/sda_s = SYNC_STAGES-deep flops of scl_i/sda_i.
- States: IDLE, Q0, Q1, Q2, Q3, plus a 2-bit latched command and the latched bit.
- Accept: cmd_valid_i & cmd_ready_o latches cmd/bit and enters Q0 next cycle. cmd_ready_o=0 in Q0..Q3.
- Advance: Q0→Q1, Q2→Q3 and Q3→IDLE each advance on a tick.
  - Q1→Q2 requires a tick with scl_s=1. Ticks with scl_s=0 are absorbed (clock stretching, unbounded wait).
- Line drive per quarter (scl_t/sda_t; L = pull low, R = release, - = hold previous):
  - START: Q0 L/R, Q1 R/R, Q2 R/L, Q3 L/L. Repeated START is legal; Q0 lowers SCL before releasing SDA.
  - STOP: Q0 L/L, Q1 R/L, Q2 R/R, Q3 R/R.
  - WRITE: Q0 L/bit, Q1 R/-, Q2 R/-, Q3 L/-.
  - READ: Q0 L/R, Q1 R/R, Q2 R/R, Q3 L/R.
- Drive outputs are registered and change the cycle after the state transition.
- Sampling: rsp_bit_o captured from sda_s on the tick ending Q2.
- Arbitration lost:
  - WRITE with bit=1 and sda_s=0 at Q2 end.
  - STOP with sda_s=0 at Q2 end.
  - On loss: release both lines next cycle, skip Q3, go IDLE, assert rsp_valid_o with arb_lost_o=1.
- Completion: rsp_valid_o=1 for exactly one cycle, coincident with the return to IDLE (cmd_ready_o=1 that cycle). A new command may be accepted in the same cycle.
- Idle holds last drive: after STOP both lines are released; after START/WRITE/READ, SCL stays low.
- Simultaneous tick and accept: the tick is not consumed by the new command; Q0 waits for the next tick.

Test Plan:
- div_clk toggles every 5 cycles; START then STOP with bus pulled up → SCL/SDA sequence per table, each quarter = 5 cycles, two rsp pulses with arb_lost=0, lines released at end.
- WRITE bit=0 then WRITE bit=1 (sda_i follows sda_t) → SDA low then released during SCL high, rsp_bit=0 then 1, arb_lost=0.
- READ with slave holding sda_i=0 → sda_t_o=1 throughout, rsp_bit_o=0; repeat with sda_i=1 → rsp_bit_o=1.
- Clock stretch: slave holds scl_i low for 37 cycles after Q1 release → Q2 entered only on the first tick after scl_s=1, no lost or duplicated quarter.
- Arbitration: WRITE bit=1 with sda_i forced 0 → rsp_valid with arb_lost=1 after Q2, both lines released, cmd_ready_o=1, Q3 skipped.
- Reset asserted in Q2 of a WRITE → scl_t_o=sda_t_o=1 within the reset, no rsp_valid; after release, START executes normally.
